iob_reset_seq: RTL and testbench

Parametrised reset/initialisation sequencer for FPGA top-level wrappers. It replaces ad-hoc combining of board reset, PLL lock and memory-controller init-done into a single reset synchroniser. It watches N ready sources through synchronisers, requires them to be stable for a hold window, and then releases N_RST reset domains in staggered order. It re-asserts all domains on loss of readiness or on an external reset request, and reports timeouts and the faulting sources.

---
 rtl/iob_reset_seq.sv | 147 ++++++++++++++
 tb/tb_iob_reset_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_reset_seq.sv
// Reset sequencer: synchronises ready flags, holds for a stable window, then releases reset domains staggered.
// rst_o[0] drops HOLD_CYCLES+1 cycles after synced readiness; any loss of readiness or ext request re-asserts all.
module iob_reset_seq #(
  parameter int N_SRC       = 2,
  parameter int N_RST       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int TIMEOUT_W   = 20
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             ext_rst_i,
  input  logic [N_SRC-1:0] ready_i,
  input  logic [N_SRC-1:0] ready_mask_i,
  output logic [N_RST-1:0] rst_o,
  output logic             all_ready_o,
  output logic             timeout_o,
  output logic [N_SRC-1:0] fault_src_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    ST_WAIT    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } state_t;

  localparam int REL_MAX = STAGGER * (N_RST - 1);
  localparam int REL_W   = (REL_MAX < 2) ? 1 : $clog2(REL_MAX + 1);
  localparam int HOLD_W  = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
  localparam logic [TIMEOUT_W-1:0] TO_MAX    = '1;
  localparam logic [TIMEOUT_W-1:0] TO_FIRE   = TO_MAX - TIMEOUT_W'(1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REL_W-1:0]     REL_LAST  = REL_W'(REL_MAX);

  logic [SYNC_STAGES-1:0][N_SRC-1:0] ready_sync;
  logic [SYNC_STAGES-1:0]            ext_sync_q;
  logic [N_SRC-1:0]                  sync_ready;
  logic                              ext_sync;
  logic                              rdy;
  logic                              go;

  state_t                state, state_nxt;
  logic [HOLD_W-1:0]     hold_cnt, hold_nxt;
  logic [REL_W-1:0]      rel_cnt, rel_nxt;
  logic [TIMEOUT_W-1:0]  to_cnt, to_nxt;
  logic                  to_fire;
  logic [N_RST-1:0]      rst_nxt;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ready_sync <= '0;
      ext_sync_q <= '0;
    end else begin
      ready_sync <= {ready_sync[SYNC_STAGES-2:0], ready_i};
      ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], ext_rst_i};
    end
  end

  assign sync_ready = ready_sync[SYNC_STAGES-1];
  assign ext_sync   = ext_sync_q[SYNC_STAGES-1];
  assign rdy        = &(sync_ready | ready_mask_i);
  assign go         = rdy & ~ext_sync;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    rel_nxt   = rel_cnt;
    to_nxt    = to_cnt;
    to_fire   = 1'b0;
    rst_nxt   = '1;
    case (state)
      ST_WAIT: begin
        if (to_cnt != TO_MAX) to_nxt = to_cnt + TIMEOUT_W'(1);
        to_fire = (to_cnt == TO_FIRE);
        if (go) begin
          state_nxt = ST_HOLD;
          hold_nxt  = '0;
        end
      end
      // A bounce back to WAIT keeps the timeout count so a flapping source still times out.
      ST_HOLD: begin
        if (!go) begin
          state_nxt = ST_WAIT;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = ST_RELEASE;
          rel_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!go) begin
          state_nxt = ST_WAIT;
          to_nxt    = '0;
        end else if (rel_cnt == REL_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          rel_nxt = rel_cnt + REL_W'(1);
        end
      end
      ST_RUN: begin
        if (!go) begin
          state_nxt = ST_WAIT;
          to_nxt    = '0;
        end
      end
      default: state_nxt = ST_WAIT;
    endcase
    for (int i = 0; i < N_RST; i++) begin
      if (state_nxt == ST_RUN) rst_nxt[i] = 1'b0;
      else if (state_nxt == ST_RELEASE && int'(rel_nxt) >= STAGGER * i) rst_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state       <= ST_WAIT;
      hold_cnt    <= '0;
      rel_cnt     <= '0;
      to_cnt      <= '0;
      rst_o       <= '1;
      all_ready_o <= 1'b0;
      timeout_o   <= 1'b0;
      fault_src_o <= '0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      rel_cnt     <= rel_nxt;
      to_cnt      <= to_nxt;
      rst_o       <= rst_nxt;
      all_ready_o <= rdy;
      if (ext_sync) begin
        timeout_o   <= 1'b0;
        fault_src_o <= '0;
      end else if (to_fire) begin
        timeout_o   <= 1'b1;
        fault_src_o <= ~sync_ready & ~ready_mask_i;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_iob_reset_seq.sv
// Bench for iob_reset_seq: directed scenarios plus random ready/ext activity against a run-length reference model.
module tb_iob_reset_seq;
  localparam int N_SRC  = 2;
  localparam int N_RST  = 2;
  localparam int SYNC   = 2;
  localparam int HOLD   = 16;
  localparam int STAG   = 4;
  localparam int TW     = 6;
  localparam int TO_MAX = (1 << TW) - 1;

  logic             clk = 1'b0;
  logic             arst = 1'b0;
  logic             ext_rst = 1'b0;
  logic [N_SRC-1:0] ready = '0;
  logic [N_SRC-1:0] mask = '0;
  logic [N_RST-1:0] rst_o;
  logic             all_ready_o;
  logic             timeout_o;
  logic [N_SRC-1:0] fault_src_o;
  logic [2:0]       state_o;

  iob_reset_seq #(
    .N_SRC(N_SRC), .N_RST(N_RST), .SYNC_STAGES(SYNC),
    .HOLD_CYCLES(HOLD), .STAGGER(STAG), .TIMEOUT_W(TW)
  ) dut (
    .clk_i(clk), .arst_i(arst), .ext_rst_i(ext_rst),
    .ready_i(ready), .ready_mask_i(mask),
    .rst_o(rst_o), .all_ready_o(all_ready_o), .timeout_o(timeout_o),
    .fault_src_o(fault_src_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_RST-1:0] rst;
    logic [2:0]       st;
    logic             ar;
    logic             to;
    logic [N_SRC-1:0] fs;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: the synchronisers are plain delay lines, and the sequence
  // position is just the length of the current unbroken run of "good" cycles.
  logic [N_SRC-1:0] pipe_r[$];
  logic             pipe_e[$];
  int               run_len;
  int               wait_cnt;
  logic             m_to;
  logic [N_SRC-1:0] m_fs;

  task automatic model_reset();
    pipe_r = {};
    pipe_e = {};
    for (int i = 0; i < SYNC; i++) begin
      pipe_r.push_back('0);
      pipe_e.push_back(1'b0);
    end
    run_len  = 0;
    wait_cnt = 0;
    m_to     = 1'b0;
    m_fs     = '0;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (arst) begin
      model_reset();
    end else begin
      logic [N_SRC-1:0] sr;
      logic se, rdy, good, fire;
      int prev;
      obs_t e;
      sr = pipe_r.pop_front();
      pipe_r.push_back(ready);
      se = pipe_e.pop_front();
      pipe_e.push_back(ext_rst);
      rdy  = &(sr | mask);
      good = rdy & ~se;
      fire = 1'b0;
      prev = run_len;
      if (prev == 0 && wait_cnt < TO_MAX) begin
        wait_cnt++;
        fire = (wait_cnt == TO_MAX);
      end
      if (prev > HOLD && !good) wait_cnt = 0;
      if (se) begin
        m_to = 1'b0;
        m_fs = '0;
      end else if (fire) begin
        m_to = 1'b1;
        m_fs = ~sr & ~mask;
      end
      run_len = good ? run_len + 1 : 0;
      for (int i = 0; i < N_RST; i++) e.rst[i] = (run_len < HOLD + 1 + STAG * i);
      if (run_len == 0) e.st = 3'd1;
      else if (run_len <= HOLD) e.st = 3'd2;
      else if (run_len <= HOLD + 1 + STAG * (N_RST - 1)) e.st = 3'd3;
      else e.st = 3'd4;
      e.ar = rdy;
      e.to = m_to;
      e.fs = m_fs;
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (arst) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      checks++;
      if ({rst_o, state_o, all_ready_o, timeout_o, fault_src_o} !== e) begin
        failures++;
        $display("FAIL seq_out cyc=%0d got rst=%b st=%0d all_rdy=%b to=%b fault=%b want rst=%b st=%0d all_rdy=%b to=%b fault=%b",
                 cyc, rst_o, state_o, all_ready_o, timeout_o, fault_src_o, e.rst, e.st, e.ar, e.to, e.fs);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [N_SRC-1:0] m);
    arst    = 1'b1;
    ext_rst = 1'b0;
    ready   = '0;
    mask    = m;
    #1;
    check("arst_rst", rst_o, 32'h3);
    check("arst_state", state_o, 32'd1);
    check("arst_all_ready", all_ready_o, 32'd0);
    check("arst_timeout", timeout_o, 32'd0);
    check("arst_fault", fault_src_o, 32'd0);
    tick(2);
    arst = 1'b0;
  endtask

  initial begin
    int lat;
    bit found;
    model_reset();
    #3;

    // Plain power-up sequence and release latency.
    do_reset(2'b00);
    ready = 2'b11;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (rst_o[0] == 1'b0) begin
        lat = i;
        break;
      end
    end
    check("rst0_latency", lat, 32'd19);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (rst_o[1] == 1'b0) begin
        lat = i;
        break;
      end
    end
    check("rst1_stagger", lat, 32'd4);
    tick(5);
    check("run_state", state_o, 32'd4);

    // One-cycle drop of a source while running.
    ready[1] = 1'b0;
    tick(1);
    ready[1] = 1'b1;
    tick(SYNC + 1);
    check("drop_rst", rst_o, 32'h3);
    tick(40);
    check("rerelease_state", state_o, 32'd4);

    // Timeout with one source missing, then late release.
    do_reset(2'b00);
    ready = 2'b01;
    tick(80);
    check("timeout_set", timeout_o, 32'd1);
    check("timeout_fault", fault_src_o, 32'h2);
    ready = 2'b11;
    tick(40);
    check("late_release_state", state_o, 32'd4);
    check("late_release_sticky", timeout_o, 32'd1);

    // Source toggling faster than the hold window never releases.
    do_reset(2'b00);
    ready = 2'b10;
    for (int i = 0; i < 14; i++) begin
      ready[0] = ~ready[0];
      tick(10);
      check("toggle_rst", rst_o, 32'h3);
    end

    // Masked source, timeout on the unmasked one, then external reset pulse.
    do_reset(2'b10);
    tick(70);
    check("mask_timeout", timeout_o, 32'd1);
    check("mask_fault", fault_src_o, 32'h1);
    ready = 2'b01;
    tick(40);
    check("mask_run", state_o, 32'd4);
    ext_rst = 1'b1;
    tick(1);
    ext_rst = 1'b0;
    tick(SYNC + 1);
    check("ext_rst_o", rst_o, 32'h3);
    check("ext_clears_timeout", timeout_o, 32'd0);
    check("ext_clears_fault", fault_src_o, 32'd0);
    tick(40);

    // Asynchronous reset in the middle of the staggered release.
    do_reset(2'b00);
    ready = 2'b11;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (rst_o == 2'b10) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_release", found, 32'd1);
    do_reset(2'b00);

    // Random activity; mask is changed only while in reset.
    for (int blk = 0; blk < 6; blk++) begin
      do_reset(2'($urandom_range(0, 3)));
      ready = 2'($urandom);
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 59) == 0) ready[$urandom_range(0, 1)] ^= 1'b1;
        ext_rst = ($urandom_range(0, 199) == 0);
        tick(1);
      end
      ext_rst = 1'b0;
    end

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
